// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter.
//   NUM_CDB_SRC / CDB_BUF_DEPTH : default source count and per-source FIFO depth
//   PHYS_REG_W / CDB_DATA_W     : physical register tag and result value widths
//   FU_*_CDB_IDX                : fixed mapping of functional units onto arbiter sources
//   cdb_packet_t                : one broadcast on the common data bus
package cdb_arbiter_pkg;

  localparam int NUM_CDB_SRC   = 4;
  localparam int CDB_BUF_DEPTH = 2;
  localparam int PHYS_REG_W    = 7;
  localparam int CDB_DATA_W    = 64;

  localparam int FU_ALU0_CDB_IDX = 0;
  localparam int FU_ALU1_CDB_IDX = 1;
  localparam int FU_MULT_CDB_IDX = 2;
  localparam int FU_LD_CDB_IDX   = 3;

  typedef struct packed {
    logic                  valid;
    logic [PHYS_REG_W-1:0] tag;
    logic [CDB_DATA_W-1:0] value;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO feeding the CDB arbiter.
//   clock/reset : rising-edge clock, asynchronous active-low reset
//   squash      : empties the FIFO at the edge; beats push and pop
//   push/push_pkt : write one packet at the tail (caller gates with !full)
//   pop         : drop the head entry (caller gates with !empty)
//   head_pkt    : current head entry
//   full/empty  : decoded from registered count only
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int PKT_W = 71
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic             push,
  input  logic [PKT_W-1:0] push_pkt,
  input  logic             pop,
  output logic [PKT_W-1:0] head_pkt,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PKT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  assign full     = (r_count == FULL_CNT);
  assign empty    = (r_count == '0);
  assign head_pkt = r_mem[r_head];

  // Storage needs no reset: entries are only observable through count.
  always_ff @(posedge clock) begin
    if (push && !squash) begin
      r_mem[r_tail] <= push_pkt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_tail <= r_tail + 1'b1;
      if (pop)  r_head <= r_head + 1'b1;
      if (push && !pop)      r_count <= r_count + 1'b1;
      else if (pop && !push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers completed FU results per source and
// broadcasts one per cycle, chosen round-robin among non-empty sources.
//   clock/reset    : rising-edge clock, asynchronous active-low reset
//   squash         : flush all buffered results, suppress next broadcast
//   fu_done_*      : per-source completed result (valid, tag, value)
//   fu_stall       : per-source FIFO full; FU must hold its result
//   cdb_valid/tag/value/src : registered broadcast and granted source index
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = NUM_CDB_SRC,
  parameter int BUF_DEPTH = CDB_BUF_DEPTH,
  parameter int DATA_W    = CDB_DATA_W,
  parameter int PHYS_W    = PHYS_REG_W,
  localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  logic [NUM_SRC-1:0]             fu_done_valid,
  input  logic [NUM_SRC-1:0][PHYS_W-1:0] fu_done_tag,
  input  logic [NUM_SRC-1:0][DATA_W-1:0] fu_done_value,
  output logic [NUM_SRC-1:0]             fu_stall,
  output logic                           cdb_valid,
  output logic [PHYS_W-1:0]              cdb_tag,
  output logic [DATA_W-1:0]              cdb_value,
  output logic [SRC_W-1:0]               cdb_src
);

  localparam int PKT_W = PHYS_W + DATA_W;

  logic [PKT_W-1:0]   w_head [NUM_SRC];
  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_pop;
  logic               w_gnt_valid;
  logic [SRC_W-1:0]   w_gnt_idx;
  logic [PKT_W-1:0]   w_gnt_pkt;
  logic [SRC_W-1:0]   r_rr_ptr;

  assign fu_stall = w_full;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    cdb_src_fifo #(
      .DEPTH (BUF_DEPTH),
      .PKT_W (PKT_W)
    ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .squash   (squash),
      .push     (fu_done_valid[i] && !w_full[i]),
      .push_pkt ({fu_done_tag[i], fu_done_value[i]}),
      .pop      (w_pop[i]),
      .head_pkt (w_head[i]),
      .full     (w_full[i]),
      .empty    (w_empty[i])
    );
    assign w_pop[i] = w_gnt_valid && (w_gnt_idx == SRC_W'(i)) && !squash;
  end

  // Rotate the scan start to rr_ptr; first non-empty source wins.
  always_comb begin
    int unsigned v_idx;
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    v_idx       = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      v_idx = (32'(r_rr_ptr) + k) % NUM_SRC;
      if (!w_gnt_valid && !w_empty[v_idx]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = SRC_W'(v_idx);
      end
    end
  end

  assign w_gnt_pkt = w_head[w_gnt_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr  <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
    end else if (squash) begin
      cdb_valid <= 1'b0;
    end else if (w_gnt_valid) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= w_gnt_pkt[PKT_W-1:DATA_W];
      cdb_value <= w_gnt_pkt[DATA_W-1:0];
      cdb_src   <= w_gnt_idx;
      r_rr_ptr  <= (w_gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + 1'b1;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts each
// cycle's broadcast, which is queued at drive time and compared after the edge.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NS = NUM_CDB_SRC;
  localparam int DP = CDB_BUF_DEPTH;

  typedef struct {
    bit          v;
    logic [6:0]  tag;
    logic [63:0] val;
    logic [1:0]  src;
  } exp_t;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                squash = 1'b0;
  logic [NS-1:0]       fu_done_valid = '0;
  logic [NS-1:0][6:0]  fu_done_tag = '0;
  logic [NS-1:0][63:0] fu_done_value = '0;
  logic [NS-1:0]       fu_stall;
  logic                cdb_valid;
  logic [6:0]          cdb_tag;
  logic [63:0]         cdb_value;
  logic [1:0]          cdb_src;

  cdb_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .fu_done_valid (fu_done_valid),
    .fu_done_tag   (fu_done_tag),
    .fu_done_value (fu_done_value),
    .fu_stall      (fu_stall),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_value     (cdb_value),
    .cdb_src       (cdb_src)
  );

  always #5 clock = ~clock;

  cdb_packet_t mq [NS][$];
  int          mrr = 0;
  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) mq[i].delete();
  endtask

  task automatic set_src(input int i, input logic [6:0] t, input logic [63:0] v);
    fu_done_valid[i] = 1'b1;
    fu_done_tag[i]   = t;
    fu_done_value[i] = v;
  endtask

  // One clock: predict, push expectation, advance, compare.
  task automatic step(output logic [NS-1:0] acc);
    exp_t        e;
    int          g;
    bit [NS-1:0] full_pre;
    cdb_packet_t p;
    e.v = 0; e.tag = '0; e.val = '0; e.src = '0;
    g = -1;
    acc = '0;
    for (int i = 0; i < NS; i++) full_pre[i] = (mq[i].size() == DP);
    if (squash) begin
      model_clear();
    end else begin
      for (int k = 0; k < NS; k++) begin
        int idx;
        idx = (mrr + k) % NS;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      if (g >= 0) begin
        p = mq[g].pop_front();
        e.v = 1; e.tag = p.tag; e.val = p.value; e.src = 2'(g);
        mrr = (g + 1) % NS;
      end
      for (int i = 0; i < NS; i++) begin
        if (fu_done_valid[i] && !full_pre[i]) begin
          p.valid = 1'b1; p.tag = fu_done_tag[i]; p.value = fu_done_value[i];
          mq[i].push_back(p);
          acc[i] = 1'b1;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check_eq("cdb_valid", 64'(cdb_valid), 64'(e.v));
    if (e.v) begin
      check_eq("cdb_tag", 64'(cdb_tag), 64'(e.tag));
      check_eq("cdb_value", cdb_value, e.val);
      check_eq("cdb_src", 64'(cdb_src), 64'(e.src));
    end
    for (int i = 0; i < NS; i++)
      check_eq($sformatf("fu_stall[%0d]", i), 64'(fu_stall[i]), 64'(mq[i].size() == DP));
  endtask

  task automatic idle(input int n);
    logic [NS-1:0] a;
    fu_done_valid = '0;
    squash = 1'b0;
    for (int c = 0; c < n; c++) step(a);
  endtask

  initial begin
    logic [NS-1:0] a;
    bit            got;
    bit            rs_ready;

    // Reset state
    #3;
    check_eq("rst_valid", 64'(cdb_valid), 64'd0);
    check_eq("rst_tag", 64'(cdb_tag), 64'd0);
    check_eq("rst_value", cdb_value, 64'd0);
    check_eq("rst_src", 64'(cdb_src), 64'd0);
    check_eq("rst_stall", 64'(fu_stall), 64'd0);
    #9 reset = 1'b1;
    idle(2);

    // Round-robin from rr_ptr=0: tags 1..4, then src0 wins over src3
    for (int i = 0; i < NS; i++) set_src(i, 7'(i + 1), 64'(100 + i));
    step(a);
    idle(4);
    set_src(FU_LD_CDB_IDX, 7'h30, 64'h33);
    set_src(FU_ALU0_CDB_IDX, 7'h31, 64'h44);
    step(a);
    idle(3);

    // Single source
    set_src(FU_ALU1_CDB_IDX, 7'h05, 64'hA);
    step(a);
    idle(3);

    // Full/stall on MULT source while others stay busy; FU holds tag A
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NS; i++)
        if (i != FU_MULT_CDB_IDX) set_src(i, 7'(16 + 4 * c + i), 64'(c * 16 + i));
      set_src(FU_MULT_CDB_IDX, 7'(8 + c), 64'(200 + c));
      step(a);
    end
    got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      for (int i = 0; i < NS; i++)
        if (i != FU_MULT_CDB_IDX) set_src(i, 7'(40 + c), 64'(300 + c));
      set_src(FU_MULT_CDB_IDX, 7'h0A, 64'd202);
      step(a);
      got = a[FU_MULT_CDB_IDX];
    end
    check_eq("mult_tagA_accepted", 64'(got), 64'd1);
    idle(12);

    // Wake-up of an RS entry waiting on tag 3
    rs_ready = 0;
    set_src(FU_ALU0_CDB_IDX, 7'h03, 64'h1234);
    step(a);
    if (cdb_valid && cdb_tag == 7'h03) rs_ready = 1;
    check_eq("rs_ready_early", 64'(rs_ready), 64'd0);
    idle(1);
    if (cdb_valid && cdb_tag == 7'h03) rs_ready = 1;
    check_eq("rs_ready", 64'(rs_ready), 64'd1);
    idle(2);

    // Squash with same-cycle push
    set_src(0, 7'h50, 64'h1); set_src(1, 7'h51, 64'h2); set_src(2, 7'h52, 64'h3);
    step(a);
    fu_done_valid = '0;
    set_src(3, 7'h53, 64'h4);
    squash = 1'b1;
    step(a);
    idle(4);

    // Asynchronous reset mid-stream with entries queued
    set_src(0, 7'h20, 64'h20); set_src(3, 7'h21, 64'h21);
    step(a);
    set_src(0, 7'h22, 64'h22); set_src(3, 7'h23, 64'h23);
    step(a);
    fu_done_valid = '0;
    reset = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(cdb_valid), 64'd0);
    check_eq("midrst_stall", 64'(fu_stall), 64'd0);
    model_clear();
    exp_q.delete();
    mrr = 0;
    #2 reset = 1'b1;
    idle(4);

    // Random traffic with occasional squash
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < NS; i++) begin
        fu_done_valid[i] = ($urandom_range(0, 2) != 0);
        fu_done_tag[i]   = 7'($urandom);
        fu_done_value[i] = {$urandom, $urandom};
      end
      squash = ($urandom_range(0, 15) == 0);
      step(a);
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
